// File: rtl/pergate_accum_late.sv
// Sums the per-gate round-polynomial contributions (points 0,1,2) over all gate provers, mod q.
// Define PERGATE_ACCUM_PARALLEL_EN for one adder per point; default build shares a single adder.
`ifndef F_NBITS
`define F_NBITS 61
`endif
`ifndef F_Q
`define F_Q ((64'd1 << 61) - 64'd1)
`endif

module field_adder #(
   parameter int             W = `F_NBITS,
   parameter logic [W-1:0]   Q = W'(`F_Q)
) (
   input  logic         clk,
   input  logic         rstb,
   input  logic         i_en,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic         o_ready,
   output logic [W-1:0] o_sum
);
   logic [W:0]   w_raw;
   logic [W:0]   w_q_ext;
   logic [W-1:0] w_mod;
   logic         r_ready;
   logic [W-1:0] r_sum;

   assign w_q_ext = {1'b0, Q};
   assign w_raw   = {1'b0, i_a} + {1'b0, i_b};
   assign w_mod   = (w_raw >= w_q_ext) ? W'(w_raw - w_q_ext) : w_raw[W-1:0];

   // ready drops for the cycle after en, so a requester never sees a stale ready.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_ready <= 1'b1;
         r_sum   <= '0;
      end else if (i_en) begin
         r_ready <= 1'b0;
         r_sum   <= w_mod;
      end else begin
         r_ready <= 1'b1;
      end
   end

   assign o_ready = r_ready;
   assign o_sum   = r_sum;
endmodule

module pergate_accum_late_bad_ngates #(
   parameter int ngates = 1
) ();
   if (ngates < 1) begin : g_err
      $error("pergate_accum_late: ngates must be >= 1");
   end
endmodule

module pergate_accum_late #(
   parameter int ngates = 8
) (
   input  logic                                 clk,
   input  logic                                 rstb,
   input  logic                                 en,
   input  logic [ngates-1:0]                    gate_ready,
   input  logic [ngates-1:0][2:0][`F_NBITS-1:0] gate_in,
   output logic                                 ready,
   output logic                                 ready_pulse,
   output logic [2:0][`F_NBITS-1:0]             sum_out
);
   localparam int W      = `F_NBITS;
   localparam int ngbits = $clog2(ngates + 1);
   localparam logic [ngbits-1:0] LAST = ngbits'(ngates - 1);
`ifdef PERGATE_ACCUM_PARALLEL_EN
   localparam int NADD = 3;
`else
   localparam int NADD = 1;
`endif

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ADD, ST_DONE} state_t;

   if (ngates < 1) begin : g_bad
      pergate_accum_late_bad_ngates #(.ngates(ngates)) u_bad ();
   end

   state_t                  r_state;
   logic [2:0][W-1:0]       r_sum;
   logic [ngbits-1:0]       r_cnt;
`ifndef PERGATE_ACCUM_PARALLEL_EN
   logic [1:0]              r_pt;
`endif
   logic                    r_add_en;
   logic                    r_en_dly;
   logic                    r_ready_pulse;

   logic                    w_start;
   logic [2:0][W-1:0]       w_row;
   logic [NADD-1:0][W-1:0]  w_add_a;
   logic [NADD-1:0][W-1:0]  w_add_b;
   logic [NADD-1:0][W-1:0]  w_add_out;
   logic [NADD-1:0]         w_add_rdy;
   logic                    w_all_rdy;

   assign w_start   = en & ~r_en_dly;
   assign w_all_rdy = &w_add_rdy;

   always_comb begin
      w_row = '0;
      for (int g = 0; g < ngates; g++) begin
         if (r_cnt == ngbits'(g)) w_row = gate_in[g];
      end
   end

   for (genvar gi = 0; gi < NADD; gi++) begin : g_add
`ifdef PERGATE_ACCUM_PARALLEL_EN
      assign w_add_a[gi] = r_sum[gi];
      assign w_add_b[gi] = w_row[gi];
`else
      assign w_add_a[gi] = r_sum[r_pt];
      assign w_add_b[gi] = w_row[r_pt];
`endif
      field_adder #(.W(W)) u_add (
         .clk     (clk),
         .rstb    (rstb),
         .i_en    (r_add_en),
         .i_a     (w_add_a[gi]),
         .i_b     (w_add_b[gi]),
         .o_ready (w_add_rdy[gi]),
         .o_sum   (w_add_out[gi])
      );
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_state       <= ST_IDLE;
         r_sum         <= '0;
         r_cnt         <= '0;
`ifndef PERGATE_ACCUM_PARALLEL_EN
         r_pt          <= '0;
`endif
         r_add_en      <= 1'b0;
         r_en_dly      <= 1'b1;
         r_ready_pulse <= 1'b0;
      end else begin
         r_en_dly      <= en;
         r_ready_pulse <= 1'b0;
         case (r_state)
            ST_IDLE: if (w_start) r_state <= ST_WAIT;
            ST_WAIT: begin
               if (&gate_ready) begin
                  r_sum <= gate_in[0];
                  r_cnt <= ngbits'(1);
`ifndef PERGATE_ACCUM_PARALLEL_EN
                  r_pt  <= '0;
`endif
                  if (ngates == 1) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_add_en <= 1'b1;
                     r_state  <= ST_ADD;
                  end
               end
            end
            ST_ADD: begin
               // The enable cycle is skipped so the adder's pre-enable ready is ignored.
               if (r_add_en) begin
                  r_add_en <= 1'b0;
               end else if (w_all_rdy) begin
`ifdef PERGATE_ACCUM_PARALLEL_EN
                  r_sum <= w_add_out;
                  r_cnt <= r_cnt + ngbits'(1);
                  if (r_cnt == LAST) r_state  <= ST_DONE;
                  else               r_add_en <= 1'b1;
`else
                  r_sum[r_pt] <= w_add_out[0];
                  if (r_pt == 2'd2) begin
                     r_pt  <= '0;
                     r_cnt <= r_cnt + ngbits'(1);
                     if (r_cnt == LAST) r_state  <= ST_DONE;
                     else               r_add_en <= 1'b1;
                  end else begin
                     r_pt     <= r_pt + 2'd1;
                     r_add_en <= 1'b1;
                  end
`endif
               end
            end
            ST_DONE: begin
               r_ready_pulse <= 1'b1;
               r_state       <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ready       = (r_state == ST_IDLE) & ~w_start;
   assign ready_pulse = r_ready_pulse;
   assign sum_out     = r_sum;
endmodule
